// File: rtl/ddr3_command_responder.sv
// ddr3_command_responder: behavioural DDR3 device model that decodes commands, tracks
// open banks/rows, and serves BL8 read/write bursts from a 256-word store.
//
// Optional feature: define DATA_MASK_EN to add the ldm/udm byte-mask inputs.
//
// Ports:
//   clk, reset                      clock and synchronous active-high reset
//   ck_en, cs_n, ras_n, cas_n, we_n DDR3 command pins, sampled on rising clk
//   address, bank_address           row/mode address and bank select
//   dq_in                           write data, captured on write beats
//   ldm, udm                        byte masks for [7:0]/[15:8] (DATA_MASK_EN only)
//   dq_out, dq_oe                   read data and its drive enable
//   dqs_out, dqs_oe                 read strobe (with one-cycle preamble) and enable
//   open_banks                      bit n set while bank n has an open row
//   error                           sticky protocol-violation flag
module ddr3_command_responder #(
    parameter int unsigned ADDRESS_BITWIDTH      = 15,
    parameter int unsigned BANK_ADDRESS_BITWIDTH = 3,
    parameter int unsigned DQ_BITWIDTH           = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             ck_en,
    input  logic                             cs_n,
    input  logic                             ras_n,
    input  logic                             cas_n,
    input  logic                             we_n,
    input  logic [ADDRESS_BITWIDTH-1:0]      address,
    input  logic [BANK_ADDRESS_BITWIDTH-1:0] bank_address,
    input  logic [DQ_BITWIDTH-1:0]           dq_in,
`ifdef DATA_MASK_EN
    input  logic                             ldm,
    input  logic                             udm,
`endif
    output logic [DQ_BITWIDTH-1:0]           dq_out,
    output logic                             dq_oe,
    output logic                             dqs_out,
    output logic                             dqs_oe,
    output logic [7:0]                       open_banks,
    output logic                             error
);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StWaitLat = 2'd1;
    localparam logic [1:0] StBurst   = 2'd2;

    localparam logic [2:0] CmdAct   = 3'b011;
    localparam logic [2:0] CmdRead  = 3'b101;
    localparam logic [2:0] CmdWrite = 3'b100;
    localparam logic [2:0] CmdPre   = 3'b010;
    localparam logic [2:0] CmdRef   = 3'b001;
    localparam logic [2:0] CmdMrs   = 3'b000;

    logic [DQ_BITWIDTH-1:0] mem_q [256];

    logic [1:0]             state_q, state_d;
    logic [2:0]             cnt_q, cnt_d;
    logic [2:0]             beat_q, beat_d;
    logic                   is_read_q, is_read_d;
    logic [2:0]             bbank_q, bbank_d;
    logic [1:0]             brow_q, brow_d;
    logic [3:0]             cl_q, cl_d;
    logic [3:0]             cwl_q, cwl_d;
    logic [7:0]             open_q, open_d;
    logic [7:0][1:0]        row_q, row_d;
    logic                   error_q, error_d;
    logic [DQ_BITWIDTH-1:0] dq_out_q, dq_out_d;
    logic                   dq_oe_q, dq_oe_d;
    logic                   dqs_out_q, dqs_out_d;
    logic                   dqs_oe_q, dqs_oe_d;

    logic                   cmd_valid;
    logic [2:0]             cmd;
    logic [2:0]             bank;
    logic                   do_beat;
    logic [2:0]             cur_beat;
    logic [7:0]             mem_idx;
    logic                   mem_we;
    logic                   unused_pins;

    assign cmd_valid   = ck_en && !cs_n;
    assign cmd         = {ras_n, cas_n, we_n};
    assign bank        = bank_address[2:0];
    assign unused_pins = ^{address, bank_address};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        beat_d    = beat_q;
        is_read_d = is_read_q;
        bbank_d   = bbank_q;
        brow_d    = brow_q;
        cl_d      = cl_q;
        cwl_d     = cwl_q;
        open_d    = open_q;
        row_d     = row_q;
        error_d   = error_q;
        dq_out_d  = '0;
        dq_oe_d   = 1'b0;
        dqs_out_d = 1'b0;
        dqs_oe_d  = 1'b0;
        do_beat   = 1'b0;

        // cnt_q reaches 0 exactly on the edge that must present/capture beat 0.
        case (state_q)
            StWaitLat: begin
                if (cnt_q == 3'd0) begin
                    state_d = StBurst;
                    beat_d  = 3'd1;
                    do_beat = 1'b1;
                end else begin
                    cnt_d    = cnt_q - 3'd1;
                    dqs_oe_d = is_read_q && (cnt_q == 3'd1);  // read preamble
                end
            end
            StBurst: begin
                do_beat = 1'b1;
                beat_d  = beat_q + 3'd1;
                if (beat_q == 3'd7) state_d = StIdle;
            end
            default: ;
        endcase

        cur_beat = (state_q == StBurst) ? beat_q : 3'd0;
        mem_idx  = {bbank_q, brow_q, cur_beat};
        mem_we   = do_beat && !is_read_q;
        if (do_beat && is_read_q) begin
            dq_out_d  = mem_q[mem_idx];
            dq_oe_d   = 1'b1;
            dqs_oe_d  = 1'b1;
            dqs_out_d = ~cur_beat[0];
        end

        if (cmd_valid) begin
            case (cmd)
                CmdAct: begin
                    if (open_q[bank]) begin
                        error_d = 1'b1;
                    end else begin
                        open_d[bank] = 1'b1;
                        row_d[bank]  = address[1:0];
                    end
                end
                CmdPre: begin
                    if (address[10]) open_d = '0;
                    else open_d[bank] = 1'b0;
                end
                CmdRef: begin
                    if (open_q != 8'd0) error_d = 1'b1;
                end
                CmdMrs: begin
                    if (bank == 3'd0) begin
                        if (!address[6]) cl_d = 4'd5 + {2'b00, address[5:4]};
                        else error_d = 1'b1;
                    end else if (bank == 3'd2) begin
                        if (!address[5]) cwl_d = 4'd5 + {2'b00, address[4:3]};
                        else error_d = 1'b1;
                    end
                end
                CmdRead, CmdWrite: begin
                    if (!open_q[bank] || state_q != StIdle) begin
                        error_d = 1'b1;
                    end else begin
                        state_d   = StWaitLat;
                        is_read_d = (cmd == CmdRead);
                        cnt_d     = (cmd == CmdRead) ? 3'(cl_q - 4'd1) : 3'(cwl_q - 4'd1);
                        bbank_d   = bank;
                        brow_d    = row_q[bank];
                    end
                end
                default: ;  // ZQCL, NOP
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= 3'd0;
            beat_q    <= 3'd0;
            is_read_q <= 1'b0;
            bbank_q   <= 3'd0;
            brow_q    <= 2'd0;
            cl_q      <= 4'd5;
            cwl_q     <= 4'd5;
            open_q    <= '0;
            row_q     <= '0;
            error_q   <= 1'b0;
            dq_out_q  <= '0;
            dq_oe_q   <= 1'b0;
            dqs_out_q <= 1'b0;
            dqs_oe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            beat_q    <= beat_d;
            is_read_q <= is_read_d;
            bbank_q   <= bbank_d;
            brow_q    <= brow_d;
            cl_q      <= cl_d;
            cwl_q     <= cwl_d;
            open_q    <= open_d;
            row_q     <= row_d;
            error_q   <= error_d;
            dq_out_q  <= dq_out_d;
            dq_oe_q   <= dq_oe_d;
            dqs_out_q <= dqs_out_d;
            dqs_oe_q  <= dqs_oe_d;
        end
    end

    // Storage is deliberately not reset; reset only blocks an in-flight write beat.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
`ifdef DATA_MASK_EN
            if (!ldm) mem_q[mem_idx][7:0] <= dq_in[7:0];
            if (!udm) mem_q[mem_idx][DQ_BITWIDTH-1:8] <= dq_in[DQ_BITWIDTH-1:8];
`else
            mem_q[mem_idx] <= dq_in;
`endif
        end
    end

    assign dq_out     = dq_out_q;
    assign dq_oe      = dq_oe_q;
    assign dqs_out    = dqs_out_q;
    assign dqs_oe     = dqs_oe_q;
    assign open_banks = open_q;
    assign error      = error_q;

endmodule

// File: tb/tb_ddr3_command_responder.sv
// Directed testbench for ddr3_command_responder. Inputs change 1 time unit after a rising
// edge; outputs are sampled at the same point, i.e. "cycle n" is the state after edge n.
module tb_ddr3_command_responder;

    localparam logic [2:0] CAct   = 3'b011;
    localparam logic [2:0] CRead  = 3'b101;
    localparam logic [2:0] CWrite = 3'b100;
    localparam logic [2:0] CPre   = 3'b010;
    localparam logic [2:0] CRef   = 3'b001;
    localparam logic [2:0] CMrs   = 3'b000;
    localparam logic [2:0] CNop   = 3'b111;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ck_en = 1'b1;
    logic        cs_n = 1'b1;
    logic        ras_n = 1'b1;
    logic        cas_n = 1'b1;
    logic        we_n = 1'b1;
    logic [14:0] address = '0;
    logic [2:0]  bank_address = '0;
    logic [15:0] dq_in = '0;
`ifdef DATA_MASK_EN
    logic        ldm = 1'b0;
    logic        udm = 1'b0;
    logic [7:0]  ldm_pat = '0;
    logic [7:0]  udm_pat = '0;
`endif
    logic [15:0] dq_out;
    logic        dq_oe;
    logic        dqs_out;
    logic        dqs_oe;
    logic [7:0]  open_banks;
    logic        error;

    int checks = 0;
    int failures = 0;
    logic [7:0][15:0] exp1;  // expected contents of bank 1, row 3

    ddr3_command_responder dut (
        .clk          (clk),
        .reset        (reset),
        .ck_en        (ck_en),
        .cs_n         (cs_n),
        .ras_n        (ras_n),
        .cas_n        (cas_n),
        .we_n         (we_n),
        .address      (address),
        .bank_address (bank_address),
        .dq_in        (dq_in),
`ifdef DATA_MASK_EN
        .ldm          (ldm),
        .udm          (udm),
`endif
        .dq_out       (dq_out),
        .dq_oe        (dq_oe),
        .dqs_out      (dqs_out),
        .dqs_oe       (dqs_oe),
        .open_banks   (open_banks),
        .error        (error)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] c, input logic [2:0] ba, input logic [14:0] a);
        ck_en = 1'b1;
        cs_n  = 1'b0;
        {ras_n, cas_n, we_n} = c;
        bank_address = ba;
        address = a;
        tick();
        cs_n = 1'b1;
        {ras_n, cas_n, we_n} = CNop;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Issues a write at edge T and drives beat b for capture at edge T+lat+b.
    task automatic run_write(input logic [2:0] ba, input int lat, input logic [7:0][15:0] d);
        issue(CWrite, ba, 15'd0);
        for (int k = 1; k < lat; k++) tick();
        for (int b = 0; b < 8; b++) begin
            dq_in = d[b];
`ifdef DATA_MASK_EN
            ldm = ldm_pat[b];
            udm = udm_pat[b];
`endif
            tick();
            checks++;
            if (dq_oe !== 1'b0 || dqs_oe !== 1'b0) begin
                failures++;
                $display("FAIL write_no_drive beat %0d: dq_oe=%b dqs_oe=%b, required 0/0",
                         b, dq_oe, dqs_oe);
            end
        end
        dq_in = '0;
`ifdef DATA_MASK_EN
        ldm = 1'b0;
        udm = 1'b0;
`endif
    endtask

    // Issues a read at edge T, holds ck_en low while the burst runs, checks every cycle.
    task automatic run_read(input logic [2:0] ba, input int lat, input logic [7:0][15:0] e);
        issue(CRead, ba, 15'd0);
        ck_en = 1'b0;
        for (int k = 1; k < lat; k++) begin
            tick();
            checks++;
            if (dq_oe !== 1'b0 || dqs_oe !== (k == lat - 1) || dqs_out !== 1'b0) begin
                failures++;
                $display("FAIL read_latency T+%0d: dq_oe=%b dqs_oe=%b dqs_out=%b, required 0/%b/0",
                         k, dq_oe, dqs_oe, dqs_out, (k == lat - 1));
            end
        end
        for (int b = 0; b < 8; b++) begin
            tick();
            checks++;
            if (dq_oe !== 1'b1 || dq_out !== e[b] || dqs_oe !== 1'b1 || dqs_out !== (b % 2 == 0))
            begin
                failures++;
                $display("FAIL read_beat %0d: dq_oe=%b dq_out=%h dqs_oe=%b dqs_out=%b, required 1/%h/1/%b",
                         b, dq_oe, dq_out, dqs_oe, dqs_out, e[b], (b % 2 == 0));
            end
        end
        tick();
        checks++;
        if (dq_oe !== 1'b0 || dqs_oe !== 1'b0 || dq_out !== 16'h0) begin
            failures++;
            $display("FAIL read_end: dq_oe=%b dqs_oe=%b dq_out=%h, required 0/0/0000",
                     dq_oe, dqs_oe, dq_out);
        end
        ck_en = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (open_banks !== 8'h00 || error !== 1'b0 || dq_oe !== 1'b0 || dqs_oe !== 1'b0 ||
            dq_out !== 16'h0 || dqs_out !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: open=%h err=%b dq_oe=%b dqs_oe=%b dq_out=%h dqs_out=%b, required all 0",
                     open_banks, error, dq_oe, dqs_oe, dq_out, dqs_out);
        end
    endtask

    task automatic test_write_read();
        issue(CAct, 3'd1, 15'd3);
        checks++;
        if (open_banks !== 8'h02) begin
            failures++;
            $display("FAIL act_open: open_banks=%h, required 02", open_banks);
        end
        for (int b = 0; b < 8; b++) exp1[b] = 16'h1000 + 16'(b);
        run_write(3'd1, 5, exp1);
        tick();
        run_read(3'd1, 5, exp1);
        checks++;
        if (error !== 1'b0) begin
            failures++;
            $display("FAIL write_read_error: error=%b, required 0", error);
        end
    endtask

`ifdef DATA_MASK_EN
    task automatic test_data_mask();
        logic [7:0][15:0] d;
        for (int b = 0; b < 8; b++) d[b] = 16'hDEAD;
        d[2] = 16'hFFFF;
        ldm_pat = 8'hFF;
        udm_pat = 8'hFB;  // only beat 2 upper byte written
        run_write(3'd1, 5, d);
        ldm_pat = '0;
        udm_pat = '0;
        exp1[2] = 16'hFF02;
        tick();
        run_read(3'd1, 5, exp1);
    endtask
`endif

    task automatic test_mode_registers();
        logic [7:0][15:0] d;
        issue(CMrs, 3'd0, 15'h0020);  // CL = 7
        issue(CMrs, 3'd2, 15'h0008);  // CWL = 6
        issue(CMrs, 3'd3, 15'h0070);  // other banks ignored
        checks++;
        if (error !== 1'b0) begin
            failures++;
            $display("FAIL mrs_legal_error: error=%b, required 0", error);
        end
        run_read(3'd1, 7, exp1);
        for (int b = 0; b < 8; b++) d[b] = 16'hA0B0 + 16'(b * 3);
        run_write(3'd1, 6, d);
        exp1 = d;
        tick();
        run_read(3'd1, 7, exp1);
        issue(CMrs, 3'd0, 15'h0050);  // illegal CL code
        checks++;
        if (error !== 1'b1) begin
            failures++;
            $display("FAIL mrs_illegal_error: error=%b, required 1", error);
        end
        run_read(3'd1, 7, exp1);
    endtask

    task automatic test_closed_bank();
        do_reset();
        issue(CRead, 3'd4, 15'd0);
        checks++;
        if (error !== 1'b1) begin
            failures++;
            $display("FAIL closed_bank_error: error=%b, required 1", error);
        end
        for (int k = 0; k < 20; k++) begin
            tick();
            checks++;
            if (dq_oe !== 1'b0 || dqs_oe !== 1'b0) begin
                failures++;
                $display("FAIL closed_bank_quiet cycle %0d: dq_oe=%b dqs_oe=%b, required 0/0",
                         k, dq_oe, dqs_oe);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0][15:0] d;
        do_reset();
        issue(CAct, 3'd1, 15'd3);
        for (int b = 0; b < 8; b++) d[b] = 16'h2000 + 16'(b);
        issue(CWrite, 3'd1, 15'd0);           // edge T
        tick();                               // T+1
        tick();                               // T+2
        issue(CRead, 3'd1, 15'd0);            // T+3, engine busy
        checks++;
        if (error !== 1'b1) begin
            failures++;
            $display("FAIL busy_error: error=%b, required 1", error);
        end
        tick();                               // T+4
        for (int b = 0; b < 8; b++) begin
            dq_in = d[b];
            tick();                           // T+5+b
            checks++;
            if (dq_oe !== 1'b0 || dqs_oe !== 1'b0) begin
                failures++;
                $display("FAIL busy_read_ignored cycle %0d: dq_oe=%b dqs_oe=%b, required 0/0",
                         b, dq_oe, dqs_oe);
            end
        end
        dq_in = '0;
        exp1 = d;
        tick();
        run_read(3'd1, 5, exp1);
    endtask

    task automatic test_precharge_refresh();
        do_reset();
        // Deselected and clock-disabled commands are ignored.
        cs_n = 1'b1;
        {ras_n, cas_n, we_n} = CAct;
        bank_address = 3'd6;
        tick();
        ck_en = 1'b0;
        cs_n = 1'b0;
        tick();
        ck_en = 1'b1;
        cs_n = 1'b1;
        {ras_n, cas_n, we_n} = CNop;
        checks++;
        if (open_banks !== 8'h00) begin
            failures++;
            $display("FAIL ignored_cmd: open_banks=%h, required 00", open_banks);
        end
        issue(CAct, 3'd0, 15'd1);
        issue(CAct, 3'd5, 15'd2);
        checks++;
        if (open_banks !== 8'h21) begin
            failures++;
            $display("FAIL act_two_banks: open_banks=%h, required 21", open_banks);
        end
        issue(CPre, 3'd0, 15'h0400);
        checks++;
        if (open_banks !== 8'h00) begin
            failures++;
            $display("FAIL pre_all: open_banks=%h, required 00", open_banks);
        end
        issue(CRef, 3'd0, 15'd0);
        issue(CPre, 3'd3, 15'd0);             // closed bank, legal
        checks++;
        if (error !== 1'b0) begin
            failures++;
            $display("FAIL ref_closed: error=%b, required 0", error);
        end
        issue(CAct, 3'd2, 15'd0);
        issue(CAct, 3'd7, 15'd0);
        issue(CPre, 3'd2, 15'd0);
        checks++;
        if (open_banks !== 8'h80) begin
            failures++;
            $display("FAIL pre_single: open_banks=%h, required 80", open_banks);
        end
        issue(CRef, 3'd0, 15'd0);
        checks++;
        if (error !== 1'b1) begin
            failures++;
            $display("FAIL ref_open: error=%b, required 1", error);
        end
        do_reset();
        issue(CAct, 3'd3, 15'd0);
        issue(CAct, 3'd3, 15'd1);
        checks++;
        if (error !== 1'b1 || open_banks !== 8'h08) begin
            failures++;
            $display("FAIL act_reopen: error=%b open_banks=%h, required 1/08", error, open_banks);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
`ifdef DATA_MASK_EN
        test_data_mask();
`endif
        test_mode_registers();
        test_closed_bank();
        test_back_to_back();
        test_precharge_refresh();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/ddr3_command_responder.md
DDR3_COMMAND_RESPONDER -- requirements
Module: ddr3_command_responder

Interface
REQ-001 SHALL have parameters: ADDRESS_BITWIDTH, default 15, row/column address width; BANK_ADDRESS_BITWIDTH, default 3, bank address width; DQ_BITWIDTH, default 16, data width (two bytes).
REQ-002 SHALL have ports: clk input 1 (clock); reset input 1 (reset, synchronous, active-high).
REQ-003 SHALL have ports: ck_en, cs_n, ras_n, cas_n, we_n, each input 1, the DDR3 command pins sampled on rising clk.
REQ-004 SHALL have ports: address input ADDRESS_BITWIDTH; bank_address input BANK_ADDRESS_BITWIDTH.
REQ-005 SHALL have ports: dq_in input DQ_BITWIDTH (write data); dq_out output DQ_BITWIDTH (read data); dq_oe output 1 (dq drive enable).
REQ-006 SHALL have ports: dqs_out output 1 (read strobe); dqs_oe output 1 (strobe drive enable); ldm, udm input 1 each (byte masks, present only per REQ-024).
REQ-007 SHALL have ports: open_banks output 8 (bit n high = bank n has an open row); error output 1 (sticky protocol-violation flag).

Function
REQ-008 SHALL decode commands only when ck_en=1 and cs_n=0, with {ras_n,cas_n,we_n}: 011 ACT, 101 READ, 100 WRITE, 010 PRE, 001 REF, 000 MRS, 110 ZQCL, 111 NOP; ck_en=0 or cs_n=1 is ignored.
REQ-009 ACT SHALL open the addressed bank and latch address[1:0] as that bank's row; ACT to an already-open bank SHALL set error, row unchanged.
REQ-010 PRE SHALL close the addressed bank, or all banks if address[10]=1; PRE to a closed bank is legal.
REQ-011 REF SHALL set error if open_banks is non-zero; ZQCL and NOP SHALL have no effect.
REQ-012 MRS with bank 0 SHALL set CL = address[6:4]+5 when address[6:4] is 0..3, else set error and keep CL.
REQ-013 MRS with bank 2 SHALL set CWL = address[5:3]+5 when address[5:3] is 0..3, else set error and keep CWL; MRS to other banks is ignored.
REQ-014 Storage SHALL be 256 words of DQ_BITWIDTH, indexed {bank[2:0], row[1:0], beat[2:0]}; bursts are BL8, one beat per clk, and command column bits are ignored.
REQ-015 READ or WRITE to a closed bank SHALL set error and be ignored.
REQ-016 Burst engine: one burst pending or active at a time; a READ or WRITE arriving while the engine is non-idle SHALL set error and be ignored.
REQ-017 Burst engine states: IDLE, WAIT_LAT, BURST.
- IDLE -> WAIT_LAT on an accepted READ/WRITE at cycle T.
- WAIT_LAT -> BURST so that beat 0 occurs at cycle T+CL (read) or T+CWL (write).
- BURST -> IDLE after beat 7.
REQ-018 Read burst:
- dq_out = mem[beat] and dq_oe=1 in cycles T+CL..T+CL+7.
- dqs_oe=1 from T+CL-1 (preamble, dqs_out=0) to T+CL+7.
- dqs_out=1 on even beats and 0 on odd beats.
REQ-019 Write burst: dq_in SHALL be captured into mem[beat] in cycles T+CWL..T+CWL+7; dq_oe and dqs_oe stay 0.
REQ-020 Bank state (open/closed, row) SHALL be latched at command acceptance; a PRE issued mid-burst SHALL NOT alter the running burst.
REQ-021 CL/CWL changes SHALL apply only to commands accepted after the MRS cycle.
REQ-022 ck_en=0 SHALL NOT stall a running burst.

Reset
REQ-023 On reset, in the same cycle:
- all banks closed, open_banks=0.
- CL=5, CWL=5.
- burst engine IDLE.
- dq_out=0, dq_oe=0, dqs_out=0, dqs_oe=0, error=0.
- storage contents not cleared.
- any in-flight burst aborted.

Configuration
REQ-024 Macro DATA_MASK_EN: when defined, ldm/udm exist, and a write beat with ldm=1 (udm=1) SHALL leave byte [7:0] ([15:8]) unchanged. When undefined, the ports are absent and all bytes are written.

Verification
REQ-025 Reset; ACT bank1 addr 3; WRITE bank1 at T=10; drive 0x1000..0x1007 in cycles 15..22; READ at T=30 -> dq_oe=1 cycles 35..42 with 0x1000..0x1007, dqs_oe=1 from cycle 34, error=0.
REQ-026 MRS bank0 address[6:4]=2 (CL=7), then READ at T -> beat 0 at T+7; address[6:4]=5 -> error=1, CL unchanged.
REQ-027 READ to bank 4 with no prior ACT -> error=1, dq_oe stays 0 for 20 cycles.
REQ-028 WRITE at T, READ at T+3 -> error=1, read ignored, write completes.
REQ-029 With DATA_MASK_EN: overwrite beat 2 with 0xFFFF and ldm=1 over old 0x1002 -> readback 0xFF02.
REQ-030 ACT banks 0 and 5; PRE with address[10]=1 -> open_banks=0; then REF -> error stays 0; REF with a bank open -> error=1.
